logic_unit_pipe: RTL and testbench
==================================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width in bits (legal values 8..64).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the completed-operation counter.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning operands and op are presented.
REQ-006 SHALL have port in_ready, output, 1, meaning the block can accept this cycle.
REQ-007 SHALL have port op, input, 3, meaning the operation select (see REQ-013).
REQ-008 SHALL have ports r2 and r3, input, WIDTH each, meaning operand A and operand B.
REQ-009 SHALL have port r1, output, WIDTH, meaning the registered result.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1), meaning the result handshake.
REQ-011 SHALL have ports zero and parity, output, 1 each, meaning r1 == 0 and the XOR-reduction of r1.
REQ-012 SHALL have port done_cnt, output, CNT_W, meaning the count of results consumed (out_valid && out_ready).

Function
REQ-013 SHALL implement op encoding:
- 000 AND
- 001 OR
- 010 XOR
- 011 NOR
- 100 XNOR
- 101 NAND
- 110 ANDN (r2 & ~r3)
- 111 PASS (r2)
REQ-014 SHALL accept a transaction on any rising edge where in_valid && in_ready.
REQ-015 SHALL be a two-stage pipeline: stage 1 registers op/r2/r3, stage 2 registers r1/zero/parity.
REQ-016 SHALL present the result of a transaction accepted on edge E with out_valid high after edge E+1 (latency 2 register stages, no bubbles).
REQ-017 SHALL sustain throughput of one transaction per cycle while out_ready is held high.
REQ-018 SHALL advance stage 2 when !s2_valid || out_ready, and advance stage 1 when !s1_valid || stage 2 advances.
REQ-019 SHALL drive in_ready = !s1_valid || (stage 2 advances), combinationally, with no dependence on in_valid.
REQ-020 SHALL hold r1, zero, parity and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL never drop or duplicate a transaction under any pattern of in_valid/out_ready, including both pipeline stages full with out_ready low.
REQ-022 SHALL compute zero and parity from the same stage-2 value as r1, so the three outputs are always coherent.
REQ-023 SHALL increment done_cnt by 1 on each edge where out_valid && out_ready, wrapping from 2^CNT_W-1 to 0.
REQ-024 SHALL handle a simultaneous accept and consume in one cycle, with both stages updating and no stall.
REQ-025 SHALL output r1 = 0, zero = 1 and parity = 0 when stage 2 is empty, with r1 don't-care-free.

Reset
REQ-026 SHALL, on rst high at a rising edge, clear s1_valid, s2_valid, r1, parity and done_cnt to 0 and set zero to 1.
REQ-027 SHALL discard in-flight transactions on reset mid-operation; in_ready SHALL be 1 in the first cycle after reset release.
REQ-028 SHALL take priority for rst over every handshake on the same edge.

Structure
REQ-029 SHALL place the op encoding constants (OP_AND..OP_PASS) in shared package alu_pkg, alongside the existing ALU definitions.
REQ-030 SHALL use one combinational sub-module, logic_op (parameter WIDTH; inputs op, a, b; output y), instantiated in stage 2; all sequential logic SHALL remain in logic_unit_pipe.

Verification
REQ-031 SHALL check XOR with r2=0x00000001 and r3=0x00000001 -> r1=0x00000000, zero=1, parity=0, two stages after accept.
REQ-032 SHALL check back-to-back XOR (0x2,0x1), OR (0x4,0x2) and ANDN (0x8,0x1) with out_ready=1 -> r1 = 0x3, 0x6, 0x8 on consecutive cycles, parity 0,0,1, done_cnt=3.
REQ-033 SHALL check backpressure: out_ready=0 while 3 transactions are offered -> in_ready falls after 2 accepts, r1 stays stable, and releasing out_ready drains all results in order.
REQ-034 SHALL check reset mid-stream with both stages full -> out_valid=0, zero=1, done_cnt=0 on the next cycle, and no stale result emerges.
REQ-035 SHALL check counter wrap with CNT_W=2 -> after 5 consumes done_cnt=1.
REQ-036 SHALL check all 8 ops at WIDTH=8 with r2=0xA5 and r3=0x0F -> 0x05, 0xAF, 0xAA, 0x50, 0x55, 0xFA, 0xA0, 0xA5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation-select width and the bitwise logic-unit
// opcode encoding used by logic_unit_pipe and its combinational core.
package alu_pkg;

    // Width of every ALU operation-select field.
    localparam int ALU_OP_W = 3;

    // Bitwise logic-unit operations.
    typedef enum logic [ALU_OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOR  = 3'b011,
        OP_XNOR = 3'b100,
        OP_NAND = 3'b101,
        OP_ANDN = 3'b110,   // a & ~b
        OP_PASS = 3'b111    // a
    } logic_op_e;

endpackage : alu_pkg

// File: rtl/logic_op.sv
// Purely combinational bitwise operator: y = op(a, b).
module logic_op
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [WIDTH-1:0]    y
);

    // Select the bitwise function named by op.
    always_comb begin
        // NOTE: y gets a default before the case so no path leaves it unassigned (no latch).
        y = '0;
        case (logic_op_e'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_NAND: y = ~(a & b);
            OP_ANDN: y = a & ~b;
            OP_PASS: y = a;
            default: y = '0;
        endcase
    end

endmodule : logic_op

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit.
// Stage 1 holds the accepted op and operands; stage 2 holds the result
// together with its zero and parity flags. A stage advances whenever it is
// empty or the stage after it is moving, so the pipe runs one transaction
// per cycle with no bubbles and never drops or duplicates under backpressure.
module logic_unit_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    r2,
    input  logic [WIDTH-1:0]    r3,
    output logic [WIDTH-1:0]    r1,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                zero,
    output logic                parity,
    output logic [CNT_W-1:0]    done_cnt
);

    // Stage 1 registers.
    logic                r_s1_valid;
    logic [ALU_OP_W-1:0] r_s1_op;
    logic [WIDTH-1:0]    r_s1_a;
    logic [WIDTH-1:0]    r_s1_b;

    // Stage 2 occupancy; its data lives directly in r1/zero/parity.
    logic                r_s2_valid;

    // Pipeline control and stage-2 input.
    logic                w_s2_adv;
    logic                w_s1_adv;
    logic [WIDTH-1:0]    w_op_y;
    logic [WIDTH-1:0]    w_r1_next;

    // Advance conditions: a stage moves when it is empty or its successor moves.
    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;

    // Bitwise core evaluated on the stage-1 contents, feeding stage 2.
    logic_op #(
        .WIDTH (WIDTH)
    ) u_logic_op (
        .op (r_s1_op),
        .a  (r_s1_a),
        .b  (r_s1_b),
        .y  (w_op_y)
    );

    // An empty stage 1 hands stage 2 a zero result so an empty output reads as 0/zero=1/parity=0.
    assign w_r1_next = r_s1_valid ? w_op_y : '0;

    // Stage 1: capture op and operands whenever the stage is free to move.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are reset as well so nothing downstream ever sees X.
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_s1_adv) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_s1_valid <= in_valid;
            r_s1_op    <= op;
            r_s1_a     <= r2;
            r_s1_b     <= r3;
        end
    end

    // Stage 2: register result and flags from one value so the outputs stay coherent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r1         <= '0;
            zero       <= 1'b1;
            parity     <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            r1         <= w_r1_next;
            zero       <= (w_r1_next == '0);
            parity     <= ^w_r1_next;
        end
    end

    // Completed-operation counter: one step per consumed result, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt <= '0;
        end else if (r_s2_valid && out_ready) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

endmodule : logic_unit_pipe

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe. A 32-bit instance is driven by
// directed and random traffic; a monitor predicts every output each cycle
// from a per-bit truth-table model and a queue of accepted transactions.
// An 8-bit instance with a 2-bit counter covers the op table and counter wrap.
module tb_logic_unit_pipe;

    typedef struct {
        logic [31:0] r1;
        logic        zero;
        logic        parity;
        int          t;
    } exp_t;

    logic        clk;
    logic        rst;

    // Main instance (WIDTH=32, CNT_W=16).
    logic        in_valid, in_ready, out_valid, out_ready, zero, parity;
    logic [2:0]  op;
    logic [31:0] r2, r3, r1;
    logic [15:0] done_cnt;

    // Small instance (WIDTH=8, CNT_W=2).
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_zero, s_parity;
    logic [2:0]  s_op;
    logic [7:0]  s_r2, s_r3, s_r1;
    logic [1:0]  s_done_cnt;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [3:0]  tt [8];        // truth table per op, indexed by {a_bit, b_bit}
    exp_t        sb [$];        // accepted, not yet consumed
    exp_t        got [$];       // what the DUT delivered on each consume
    logic [15:0] exp_done = '0;
    int          cyc = 0;
    logic        armed = 1'b0;
    exp_t        m_e;
    logic        m_vis;
    logic        m_rdy;

    logic [7:0]  s_log [$];
    int          s_cons = 0;
    logic        s_have5 = 1'b0;
    logic [1:0]  s_done5 = '0;

    logic_unit_pipe #(.WIDTH(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .r2        (r2),
        .r3        (r3),
        .r1        (r1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .zero      (zero),
        .parity    (parity),
        .done_cnt  (done_cnt)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_small (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .op        (s_op),
        .r2        (s_r2),
        .r3        (s_r3),
        .r1        (s_r1),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .zero      (s_zero),
        .parity    (s_parity),
        .done_cnt  (s_done_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each op is a 2-input truth table applied bit by bit.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int t);
        exp_t       e;
        logic [3:0] row;
        row = tt[o];
        for (int i = 0; i < 32; i++) e.r1[i] = row[{a[i], b[i]}];
        e.zero   = (e.r1 == 32'd0);
        e.parity = ($countones(e.r1) % 2) == 1;
        e.t      = t;
        return e;
    endfunction

    // Main monitor: predict outputs from the queue, then update the model for the coming edge.
    always @(negedge clk) begin
        if (armed) begin
            m_vis = (sb.size() > 0) && (cyc - sb[0].t >= 2);
            m_rdy = (sb.size() < 2) || out_ready;
            check("out_valid", out_valid, m_vis);
            check("in_ready", in_ready, m_rdy);
            check("done_cnt", done_cnt, exp_done);
            if (m_vis) begin
                check("r1", r1, sb[0].r1);
                check("zero", zero, sb[0].zero);
                check("parity", parity, sb[0].parity);
            end else begin
                check("idle_r1", r1, 0);
                check("idle_zero", zero, 1);
                check("idle_parity", parity, 0);
            end
            if (!rst) begin
                if (m_vis && out_ready) begin
                    got.push_back('{r1: r1, zero: zero, parity: parity, t: cyc});
                    void'(sb.pop_front());
                    exp_done = exp_done + 16'd1;
                end
                if (in_valid && m_rdy) begin
                    m_e = model(op, r2, r3, cyc);
                    sb.push_back(m_e);
                end
            end
        end
        if (rst) begin
            armed    = 1'b1;
            sb.delete();
            exp_done = '0;
        end
        cyc++;
    end

    // Small-instance monitor: log consumed results, snapshot the counter after five consumes.
    always @(negedge clk) begin
        if (s_cons == 5 && !s_have5) begin
            s_done5 = s_done_cnt;
            s_have5 = 1'b1;
        end
        if (s_out_valid === 1'b1 && s_out_ready && !rst) begin
            s_log.push_back(s_r1);
            s_cons++;
        end
    end

    task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int   n;
        logic acc;
        n = 0;
        in_valid = 1'b1; op = o; r2 = a; r3 = b;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (sb.size() > 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [7:0]  s_exp [8];
    logic [2:0]  bp_op [3];
    logic [31:0] bp_a [3];
    logic [31:0] bp_b [3];

    initial begin
        int k;
        int n;
        logic acc;

        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0001;
        tt[4] = 4'b1001; tt[5] = 4'b0111; tt[6] = 4'b0100; tt[7] = 4'b1100;
        s_exp[0] = 8'h05; s_exp[1] = 8'hAF; s_exp[2] = 8'hAA; s_exp[3] = 8'h50;
        s_exp[4] = 8'h55; s_exp[5] = 8'hFA; s_exp[6] = 8'hA0; s_exp[7] = 8'hA5;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; op = '0; r2 = '0; r3 = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_op = '0; s_r2 = '0; s_r3 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // All eight ops at WIDTH=8, streamed back to back.
        s_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_in_valid = 1'b1; s_op = 3'(i); s_r2 = 8'hA5; s_r3 = 8'h0F;
            n = 0;
            do begin
                @(negedge clk);
                acc = s_in_ready;
                @(posedge clk); #1;
                n++;
            end while (!acc && n < 50);
            if (!acc) check("small_send_timeout", 0, 1);
        end
        s_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("small_count", s_log.size(), 8);
        if (s_log.size() == 8)
            for (int i = 0; i < 8; i++) check($sformatf("small_op%0d", i), s_log[i], s_exp[i]);
        check("wrap_seen5", s_have5, 1);
        check("wrap_cnt5", s_done5, 2'd1);
        @(negedge clk);
        check("wrap_cnt8", s_done_cnt, 2'd0);
        @(posedge clk); #1;

        // XOR of equal operands yields zero.
        got.delete();
        out_ready = 1'b1;
        send(3'b010, 32'h1, 32'h1);
        drain();
        check("xor_count", got.size(), 1);
        if (got.size() == 1) begin
            check("xor_r1", got[0].r1, 32'h0);
            check("xor_zero", got[0].zero, 1);
            check("xor_parity", got[0].parity, 0);
        end

        // Back-to-back XOR, OR, ANDN with the output always ready.
        pulse_reset();
        got.delete();
        out_ready = 1'b1;
        send(3'b010, 32'h2, 32'h1);
        send(3'b001, 32'h4, 32'h2);
        send(3'b110, 32'h8, 32'h1);
        drain();
        check("b2b_count", got.size(), 3);
        if (got.size() == 3) begin
            check("b2b_r1_0", got[0].r1, 32'h3);
            check("b2b_r1_1", got[1].r1, 32'h6);
            check("b2b_r1_2", got[2].r1, 32'h8);
            check("b2b_par_0", got[0].parity, 0);
            check("b2b_par_1", got[1].parity, 0);
            check("b2b_par_2", got[2].parity, 1);
            check("b2b_gap_01", got[1].t - got[0].t, 1);
            check("b2b_gap_12", got[2].t - got[1].t, 1);
        end
        @(negedge clk);
        check("b2b_done_cnt", done_cnt, 16'd3);
        @(posedge clk); #1;

        // Backpressure: three offers with the output stalled.
        got.delete();
        bp_op[0] = 3'b000; bp_a[0] = 32'hF0; bp_b[0] = 32'h3C;
        bp_op[1] = 3'b001; bp_a[1] = 32'h01; bp_b[1] = 32'h10;
        bp_op[2] = 3'b010; bp_a[2] = 32'hFF; bp_b[2] = 32'h0F;
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (k < 3);
            if (k < 3) begin op = bp_op[k]; r2 = bp_a[k]; r3 = bp_b[k]; end
            @(negedge clk);
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("bp_accepts", k, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_no_output", got.size(), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        while (k < 3 && n < 50) begin
            in_valid = 1'b1; op = bp_op[k]; r2 = bp_a[k]; r3 = bp_b[k];
            @(negedge clk);
            if (in_ready) k++;
            @(posedge clk); #1;
            n++;
        end
        drain();
        check("bp_count", got.size(), 3);
        if (got.size() == 3) begin
            check("bp_r1_0", got[0].r1, 32'h30);
            check("bp_r1_1", got[1].r1, 32'h11);
            check("bp_r1_2", got[2].r1, 32'hF0);
        end

        // Random traffic in three backpressure regimes.
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 800; c++) begin
                in_valid = ($urandom % 4) != 0;
                op = 3'($urandom % 8);
                r2 = (($urandom % 8) == 0) ? 32'h0 : $urandom;
                r3 = (($urandom % 4) == 0) ? r2 : $urandom;
                case (ph)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ($urandom % 2) == 0;
                    default: out_ready = ($urandom % 4) == 0;
                endcase
                @(posedge clk); #1;
            end
        end
        drain();

        // Reset with both stages full: everything in flight is discarded.
        got.delete();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; op = 3'($urandom % 8); r2 = $urandom; r3 = $urandom;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rs_full_in_ready", in_ready, 0);
        check("rs_full_out_valid", out_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rs_out_valid", out_valid, 0);
        check("rs_zero", zero, 1);
        check("rs_done_cnt", done_cnt, 16'd0);
        check("rs_in_ready", in_ready, 1);
        repeat (6) @(posedge clk);
        #1;
        check("rs_no_stale", got.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_logic_unit_pipe
